// File: rtl/filter_frame_scheduler.sv
// Frame/line sequencer for the VGA filter: pixel coordinates, window qualification,
// frame-aligned mode switching and sticky timing-error flags.
module filter_frame_scheduler #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned K      = 3
) (
    input  logic       VGA_CLK,
    input  logic       reset_n,
    input  logic       iVGA_HS,
    input  logic       iVGA_VS,
    input  logic       iVGA_BLANK_N,
    input  logic [5:0] mode_req,
    input  logic       err_clr,
    output logic [2:0] mode_active,
    output logic       mode_chg,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_valid,
    output logic       win_valid,
    output logic       frame_start,
    output logic       line_start,
    output logic       win_flush,
    output logic       line_err,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);
    typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE, HBLANK} state_t;

    localparam logic [9:0]  X_MAX       = 10'(WIDTH - 1);
    localparam logic [9:0]  Y_MAX       = 10'(HEIGHT - 1);
    localparam logic [9:0]  WIN_MIN     = 10'(K - 1);
    localparam logic [10:0] LINE_LEN    = 11'(WIDTH);
    localparam logic [10:0] FRAME_LINES = 11'(HEIGHT);

    state_t      r_state;
    logic        r_vs, r_vs_d, r_blank, r_blank_d, r_err_clr;
    logic [2:0]  r_mode_pend;
    logic [10:0] r_pcnt, r_lcnt;
    logic [2:0]  r_mode_active;
    logic        r_mode_chg;
    logic [9:0]  r_x, r_y;
    logic        r_pix_valid, r_win_valid;
    logic        r_frame_start, r_line_start, r_win_flush;
    logic        r_line_err, r_frame_err;
    logic [7:0]  r_frame_cnt;

    logic        w_vs_fall, w_blank_rise, w_blank_fall;
    logic [2:0]  w_mode_enc;
    logic [9:0]  w_x_inc, w_y_inc;
    logic [10:0] w_pcnt_inc, w_lcnt_inc;
    logic        w_y_win;
    logic        w_unused_hs;

    // Blank edges already delimit lines, so HS carries no information here.
    assign w_unused_hs = iVGA_HS;

    assign w_vs_fall    = r_vs_d & ~r_vs;
    assign w_blank_rise = ~r_blank_d & r_blank;
    assign w_blank_fall = r_blank_d & ~r_blank;

    assign w_x_inc    = (r_x >= X_MAX) ? X_MAX : r_x + 10'd1;
    assign w_y_inc    = (r_y >= Y_MAX) ? Y_MAX : r_y + 10'd1;
    assign w_pcnt_inc = (&r_pcnt) ? r_pcnt : r_pcnt + 11'd1;
    assign w_lcnt_inc = (&r_lcnt) ? r_lcnt : r_lcnt + 11'd1;
    assign w_y_win    = (r_y >= WIN_MIN);

    always_comb begin
        w_mode_enc = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (mode_req[i] && (w_mode_enc == 3'd0)) w_mode_enc = 3'(i + 1);
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            r_vs          <= 1'b0;
            r_vs_d        <= 1'b0;
            r_blank       <= 1'b0;
            r_blank_d     <= 1'b0;
            r_err_clr     <= 1'b0;
            r_mode_pend   <= '0;
            r_state       <= WAIT_VS;
            r_pcnt        <= '0;
            r_lcnt        <= '0;
            r_mode_active <= '0;
            r_mode_chg    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_valid   <= 1'b0;
            r_win_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_win_flush   <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_vs        <= iVGA_VS;
            r_vs_d      <= r_vs;
            r_blank     <= iVGA_BLANK_N;
            r_blank_d   <= r_blank;
            r_err_clr   <= err_clr;
            r_mode_pend <= w_mode_enc;

            r_frame_start <= 1'b0;
            r_win_flush   <= 1'b0;
            r_line_start  <= 1'b0;
            r_mode_chg    <= 1'b0;

            // Clear first so that an error detected in the same cycle overrides it.
            if (r_err_clr) begin
                r_line_err  <= 1'b0;
                r_frame_err <= 1'b0;
            end

            if (w_vs_fall) begin
                if (r_state != WAIT_VS) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    if (r_lcnt != FRAME_LINES) r_frame_err <= 1'b1;
                end
                r_frame_start <= 1'b1;
                r_win_flush   <= 1'b1;
                r_mode_active <= r_mode_pend;
                r_mode_chg    <= (r_mode_pend != r_mode_active);
                r_y           <= '0;
                r_lcnt        <= '0;
                if (w_blank_rise) begin
                    r_state      <= ACTIVE;
                    r_line_start <= 1'b1;
                    r_x          <= '0;
                    r_pcnt       <= 11'd1;
                    r_pix_valid  <= 1'b1;
                    r_win_valid  <= (WIN_MIN == 10'd0);
                end else begin
                    r_state     <= VBLANK;
                    r_pix_valid <= 1'b0;
                    r_win_valid <= 1'b0;
                end
            end else begin
                case (r_state)
                    WAIT_VS: begin
                        r_pix_valid <= 1'b0;
                        r_win_valid <= 1'b0;
                    end
                    VBLANK, HBLANK: begin
                        if (w_blank_rise) begin
                            r_state      <= ACTIVE;
                            r_line_start <= 1'b1;
                            r_x          <= '0;
                            r_pcnt       <= 11'd1;
                            r_pix_valid  <= 1'b1;
                            r_win_valid  <= (WIN_MIN == 10'd0) && w_y_win;
                        end
                    end
                    ACTIVE: begin
                        if (w_blank_fall) begin
                            r_state     <= HBLANK;
                            r_pix_valid <= 1'b0;
                            r_win_valid <= 1'b0;
                            r_y         <= w_y_inc;
                            r_lcnt      <= w_lcnt_inc;
                            if (r_pcnt != LINE_LEN) r_line_err <= 1'b1;
                        end else begin
                            r_x         <= w_x_inc;
                            r_pcnt      <= w_pcnt_inc;
                            r_win_valid <= (w_x_inc >= WIN_MIN) && w_y_win;
                        end
                    end
                    default: r_state <= WAIT_VS;
                endcase
            end
        end
    end

    assign mode_active = r_mode_active;
    assign mode_chg    = r_mode_chg;
    assign x           = r_x;
    assign y           = r_y;
    assign pix_valid   = r_pix_valid;
    assign win_valid   = r_win_valid;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign win_flush   = r_win_flush;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
